param_cpu_core: RTL and testbench

PARAM_CPU_CORE -- requirements
Module: param_cpu_core

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/cpu_alu.sv | 31 +++
 rtl/param_cpu_core.sv | 215 +++++++++++++++++++++
 tb/tb_param_cpu_core.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the parameterised accumulator CPU core:
// opcode constants, opcode field width and the core state encoding.
package cpu_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_STA = 4'h4;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_EXEC  = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational add/subtract unit for the CPU core.
// Ports:
//   i_a, i_b  operands (DATA_W)
//   i_sub     1 = i_a - i_b computed as i_a + ~i_b + 1
//   o_result  DATA_W-bit result
//   o_carry   carry out of the MSB (for subtract: 1 = no borrow)
//   o_zero    result equals zero
module cpu_alu #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_sum;

  always_comb begin
    w_b   = i_sub ? ~i_b : i_b;
    w_sum = {1'b0, i_a} + {1'b0, w_b} + (DATA_W+1)'(i_sub);
  end

  assign o_result = w_sum[DATA_W-1:0];
  assign o_carry  = w_sum[DATA_W];
  assign o_zero   = (w_sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/param_cpu_core.sv
// Parameterised accumulator CPU with a load port that fills its internal
// program/data memory, then runs a two-cycle FETCH/EXEC loop.
// Optional feature: define PARAM_CPU_COND_JUMP_EN to enable JC/JZ;
// otherwise those opcodes behave as NOP.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   prog_en           request programming mode (also aborts execution)
//   prog_valid/data   word offered to the loader
//   prog_ready        loader accepts a word this cycle
//   done_load         memory completely filled during the current load
//   out_data/valid    output register and its one-cycle update pulse
//   carry_flag/zero_flag  ALU flags
//   halted            core is in HALT
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              done_load,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              halted
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [DATA_W-1:0] r_ir, w_ir_nxt;
  logic [DATA_W-1:0] r_a, w_a_nxt;
  logic [DATA_W-1:0] r_out_data, w_out_data_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_full, w_full_nxt;
  logic              r_cf, w_cf_nxt;
  logic              r_zf, w_zf_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  logic [OPC_W-1:0]  w_opcode;
  logic [ADDR_W-1:0] w_operand;
  logic [DATA_W-1:0] w_mem_op;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_carry;
  logic              w_alu_zero;
  logic              w_prog_ready;

  assign w_opcode  = r_ir[DATA_W-1 -: OPC_W];
  assign w_operand = r_ir[ADDR_W-1:0];
  assign w_mem_op  = r_mem[w_operand];

  assign w_prog_ready = (r_state == ST_LOAD) && prog_en && !r_full;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a      (r_a),
    .i_b      (w_mem_op),
    .i_sub    (w_opcode == OP_SUB),
    .o_result (w_alu_res),
    .o_carry  (w_alu_carry),
    .o_zero   (w_alu_zero)
  );

  // State and architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_HALT;
      r_pc        <= '0;
      r_ptr       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_full      <= 1'b0;
      r_cf        <= 1'b0;
      r_zf        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ptr       <= w_ptr_nxt;
      r_ir        <= w_ir_nxt;
      r_a         <= w_a_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_full      <= w_full_nxt;
      r_cf        <= w_cf_nxt;
      r_zf        <= w_zf_nxt;
    end
  end

  // Memory array: combinational read, synchronous write, contents survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ptr_nxt       = r_ptr;
    w_ir_nxt        = r_ir;
    w_a_nxt         = r_a;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = 1'b0;
    w_full_nxt      = r_full;
    w_cf_nxt        = r_cf;
    w_zf_nxt        = r_zf;
    w_mem_we        = 1'b0;
    w_mem_addr      = r_ptr;
    w_mem_wdata     = prog_data;

    case (r_state)
      ST_HALT: begin
        if (prog_en) begin
          w_state_nxt = ST_LOAD;
          w_ptr_nxt   = '0;
          w_full_nxt  = 1'b0;
        end
      end

      ST_LOAD: begin
        if (!prog_en) begin
          w_state_nxt = ST_FETCH;
          w_pc_nxt    = '0;
          w_a_nxt     = '0;
          w_cf_nxt    = 1'b0;
          w_zf_nxt    = 1'b0;
          w_full_nxt  = 1'b0;
        end else if (prog_valid && w_prog_ready) begin
          w_mem_we = 1'b1;
          // Last slot: mark full and park the pointer instead of wrapping
          if (r_ptr == ADDR_W'(DEPTH-1)) w_full_nxt = 1'b1;
          else                           w_ptr_nxt  = r_ptr + 1'b1;
        end
      end

      ST_FETCH: begin
        if (prog_en) begin
          w_state_nxt = ST_LOAD;
          w_ptr_nxt   = '0;
          w_full_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_EXEC;
          w_ir_nxt    = r_mem[r_pc];
          w_pc_nxt    = r_pc + 1'b1;
        end
      end

      ST_EXEC: begin
        if (prog_en) begin
          // Abort: nothing from the current instruction is committed
          w_state_nxt = ST_LOAD;
          w_ptr_nxt   = '0;
          w_full_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_FETCH;
          case (w_opcode)
            OP_NOP: ;
            OP_LDA: w_a_nxt = w_mem_op;
            OP_ADD, OP_SUB: begin
              w_a_nxt  = w_alu_res;
              w_cf_nxt = w_alu_carry;
              w_zf_nxt = w_alu_zero;
            end
            OP_STA: begin
              w_mem_we    = 1'b1;
              w_mem_addr  = w_operand;
              w_mem_wdata = r_a;
            end
            OP_LDI: w_a_nxt = DATA_W'(r_ir[DATA_W-5:0]);
            OP_JMP: w_pc_nxt = w_operand;
            OP_JC: begin
`ifdef PARAM_CPU_COND_JUMP_EN
              if (r_cf) w_pc_nxt = w_operand;
`endif
            end
            OP_JZ: begin
`ifdef PARAM_CPU_COND_JUMP_EN
              if (r_zf) w_pc_nxt = w_operand;
`endif
            end
            OP_OUT: begin
              w_out_data_nxt  = r_a;
              w_out_valid_nxt = 1'b1;
            end
            OP_HLT: w_state_nxt = ST_HALT;
            default: ;
          endcase
        end
      end

      default: w_state_nxt = ST_HALT;
    endcase
  end

  assign prog_ready = w_prog_ready;
  assign done_load  = r_full;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign carry_flag = r_cf;
  assign zero_flag  = r_zf;
  assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_param_cpu_core.sv
// Self-checking bench for param_cpu_core (DATA_W=8, ADDR_W=4).
module tb_param_cpu_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_en = 1'b0;
  logic       prog_valid = 1'b0;
  logic [7:0] prog_data = 8'h00;
  logic       prog_ready;
  logic       done_load;
  logic [7:0] out_data;
  logic       out_valid;
  logic       carry_flag;
  logic       zero_flag;
  logic       halted;

  param_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_en    (prog_en),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .done_load  (done_load),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       cf;
    logic       zf;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         n_out  = 0;
  logic [7:0] pbuf [16];

  // Scoreboard: every out_valid pulse pops one expected output
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: out_data=%h but no output was expected", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data !== mon_e.data || carry_flag !== mon_e.cf || zero_flag !== mon_e.zf) begin
          errors++;
          $display("FAIL out_word: got data=%h cf=%b zf=%b, want data=%h cf=%b zf=%b",
                   out_data, carry_flag, zero_flag, mon_e.data, mon_e.cf, mon_e.zf);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic c, input logic z);
    exp_t e;
    e.data = d;
    e.cf   = c;
    e.zf   = z;
    exp_q.push_back(e);
  endtask

  task automatic clear_buf();
    for (int i = 0; i < 16; i++) pbuf[i] = 8'h00;
  endtask

  // Enter LOAD (from any state) and write pbuf[0..n-1], optionally with idle gaps
  task automatic load_buf(input int n, input bit gaps);
    int g;
    prog_en    = 1'b1;
    prog_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
      prog_valid = 1'b1;
      prog_data  = pbuf[i];
      @(posedge clk); #1;
      prog_valid = 1'b0;
    end
  endtask

  // Leave LOAD and run until HALT within a cycle budget
  task automatic run_prog(input string name);
    int cyc;
    prog_en    = 1'b0;
    prog_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!halted && cyc < 200);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s_halt_timeout: halted=%b after %0d cycles, want 1", name, halted, cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_out: %0d expected outputs never appeared, want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset(input string tag);
    rst        = 1'b1;
    prog_valid = 1'b0;
    #2;
    checks++; if (halted !== 1'b1)     begin errors++; $display("FAIL %s_halted: got %b want 1", tag, halted); end
    checks++; if (done_load !== 1'b0)  begin errors++; $display("FAIL %s_done_load: got %b want 0", tag, done_load); end
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL %s_prog_ready: got %b want 0", tag, prog_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL %s_out_valid: got %b want 0", tag, out_valid); end
    checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL %s_out_data: got %h want 00", tag, out_data); end
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL %s_carry: got %b want 0", tag, carry_flag); end
    checks++; if (zero_flag !== 1'b0)  begin errors++; $display("FAIL %s_zero: got %b want 0", tag, zero_flag); end
    @(posedge clk); #1;
    rst     = 1'b0;
    prog_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n0;
    clear_buf();
    pbuf[0] = 8'h1E; pbuf[1] = 8'h2F; pbuf[2] = 8'hE0; pbuf[3] = 8'hF0;
    pbuf[14] = 8'h1C; pbuf[15] = 8'h0E;
    push_exp(8'h2A, 1'b0, 1'b0);
    n0 = n_out;
    load_buf(16, 1'b0);
    checks++; if (done_load !== 1'b1) begin errors++; $display("FAIL basic_done_load: got %b want 1", done_load); end
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_full: got %b want 0", prog_ready); end
    run_prog("basic");
    checks++; if (n_out - n0 != 1)     begin errors++; $display("FAIL basic_pulses: got %0d want 1", n_out - n0); end
    checks++; if (out_data !== 8'h2A)  begin errors++; $display("FAIL basic_out_data: got %h want 2a", out_data); end
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL basic_cf: got %b want 0", carry_flag); end
    checks++; if (zero_flag !== 1'b0)  begin errors++; $display("FAIL basic_zf: got %b want 0", zero_flag); end
  endtask

  task automatic test_add_carry();
    clear_buf();
    pbuf[0] = 8'h5F; pbuf[1] = 8'h24; pbuf[2] = 8'hE0; pbuf[3] = 8'hF0; pbuf[4] = 8'hF1;
    push_exp(8'h00, 1'b0, 1'b0);
    load_buf(16, 1'b0);
    // OUT samples flags before ADD's result? No: ADD precedes OUT, so flags are set
    exp_q.delete();
    push_exp(8'h00, 1'b1, 1'b1);
    run_prog("add");
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL add_cf: got %b want 1", carry_flag); end
    checks++; if (zero_flag !== 1'b1)  begin errors++; $display("FAIL add_zf: got %b want 1", zero_flag); end
  endtask

  task automatic test_sub_borrow();
    clear_buf();
    pbuf[0] = 8'h53; pbuf[1] = 8'h35; pbuf[2] = 8'hE0; pbuf[3] = 8'hF0; pbuf[5] = 8'h05;
    push_exp(8'hFE, 1'b0, 1'b0);
    load_buf(16, 1'b0);
    run_prog("sub");
    checks++; if (out_data !== 8'hFE) begin errors++; $display("FAIL sub_a: got %h want fe", out_data); end
  endtask

  task automatic test_latency();
    pbuf[0] = 8'hF0;
    load_buf(1, 1'b0);
    prog_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL lat_exec: halted=%b want 0", halted); end
    @(posedge clk); #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL lat_halt: halted=%b want 1", halted); end
  endtask

  task automatic test_jump_store();
    clear_buf();
    pbuf[0] = 8'h65; pbuf[1] = 8'h59; pbuf[2] = 8'hE0; pbuf[3] = 8'hF0;
    pbuf[5] = 8'h54; pbuf[6] = 8'hE0; pbuf[7] = 8'h79; pbuf[8] = 8'hF0;
    pbuf[9] = 8'h56; pbuf[10] = 8'hE0; pbuf[11] = 8'hF0;
    push_exp(8'h04, 1'b0, 1'b0);
    load_buf(16, 1'b0);
    run_prog("jmp");
    clear_buf();
    pbuf[0] = 8'h59; pbuf[1] = 8'h4E; pbuf[2] = 8'h50; pbuf[3] = 8'h1E;
    pbuf[4] = 8'hE0; pbuf[5] = 8'hF0;
    push_exp(8'h09, 1'b0, 1'b0);
    load_buf(16, 1'b0);
    run_prog("sta_lda");
  endtask

  task automatic test_cond_jump();
    clear_buf();
    pbuf[0] = 8'h57; pbuf[1] = 8'h38; pbuf[2] = 8'h8A; pbuf[3] = 8'h51;
    pbuf[4] = 8'hE0; pbuf[5] = 8'hF0; pbuf[8] = 8'h07;
    pbuf[10] = 8'h52; pbuf[11] = 8'hE0; pbuf[12] = 8'hF0;
`ifdef PARAM_CPU_COND_JUMP_EN
    push_exp(8'h02, 1'b1, 1'b1);
`else
    push_exp(8'h01, 1'b1, 1'b1);
`endif
    load_buf(16, 1'b0);
    run_prog("jz");
  endtask

  task automatic test_back_to_back();
    int n0;
    clear_buf();
    pbuf[0] = 8'h53; pbuf[1] = 8'hE0; pbuf[2] = 8'h2F; pbuf[3] = 8'hE0;
    pbuf[4] = 8'hF0; pbuf[15] = 8'hFE;
    push_exp(8'h03, 1'b0, 1'b0);
    push_exp(8'h01, 1'b1, 1'b0);
    n0 = n_out;
    load_buf(16, 1'b0);
    run_prog("b2b");
    checks++; if (n_out - n0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", n_out - n0); end
  endtask

  task automatic test_load_full();
    int g;
    int n0;
    for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
    pbuf[0] = 8'h55; pbuf[1] = 8'hE0; pbuf[2] = 8'hF0;
    prog_en    = 1'b1;
    prog_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      g = $urandom_range(0, 3);
      repeat (g) begin @(posedge clk); #1; end
      if (i == 15) begin
        checks++;
        if (done_load !== 1'b0) begin errors++; $display("FAIL full_early: done_load=%b after 15 writes, want 0", done_load); end
      end
      prog_valid = 1'b1;
      prog_data  = pbuf[i];
      @(posedge clk); #1;
      prog_valid = 1'b0;
    end
    checks++; if (done_load !== 1'b1)  begin errors++; $display("FAIL full_set: done_load=%b want 1", done_load); end
    prog_valid = 1'b1;
    prog_data  = 8'h5A;
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL full_ready17: prog_ready=%b want 0", prog_ready); end
    repeat (2) begin @(posedge clk); #1; end
    prog_valid = 1'b0;
    checks++; if (done_load !== 1'b1)  begin errors++; $display("FAIL full_hold: done_load=%b want 1", done_load); end
    push_exp(8'h05, 1'b0, 1'b0);
    n0 = n_out;
    run_prog("full");
    checks++; if (n_out - n0 != 1)    begin errors++; $display("FAIL full_pulses: got %0d want 1", n_out - n0); end
    checks++; if (done_load !== 1'b0) begin errors++; $display("FAIL full_clear: done_load=%b want 0", done_load); end
  endtask

  task automatic test_abort();
    clear_buf();
    pbuf[0] = 8'h57; pbuf[1] = 8'h49; pbuf[2] = 8'hF0; pbuf[9] = 8'h33;
    load_buf(16, 1'b0);
    prog_en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    // now executing STA 9
    prog_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (prog_ready !== 1'b1) begin errors++; $display("FAIL abort_load: prog_ready=%b want 1", prog_ready); end
    checks++; if (halted !== 1'b0)     begin errors++; $display("FAIL abort_halted: got %b want 0", halted); end
    checks++; if (done_load !== 1'b0)  begin errors++; $display("FAIL abort_done: got %b want 0", done_load); end
    pbuf[0] = 8'h19; pbuf[1] = 8'hE0; pbuf[2] = 8'hF0;
    push_exp(8'h33, 1'b0, 1'b0);
    load_buf(3, 1'b0);
    run_prog("abort");
    // reset in the middle of a load, then reload from address 0
    pbuf[0] = 8'hF0; pbuf[1] = 8'hF0; pbuf[2] = 8'hF0;
    load_buf(3, 1'b0);
    test_reset("mid_load");
    pbuf[0] = 8'h5C; pbuf[1] = 8'hE0; pbuf[2] = 8'hF0;
    push_exp(8'h0C, 1'b0, 1'b0);
    load_buf(3, 1'b0);
    run_prog("reload");
  endtask

  initial begin
    test_reset("por");
    test_basic();
    test_add_carry();
    test_sub_borrow();
    test_latency();
    test_jump_store();
    test_cond_jump();
    test_back_to_back();
    test_load_full();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
